gp_reservation_station: RTL and testbench
=========================================

GP_RESERVATION_STATION -- requirements
Module: gp_reservation_station

Interface
REQ-001 Parameter ENTRIES, default 4, number of reservation entries (2..16).
REQ-002 Parameter RS_ID_WIDTH, default 5, width of reservation-station IDs.
REQ-003 Parameter RS_BASE_ID, default 0, ID of entry 0; entry k owns ID RS_BASE_ID+k, truncated to RS_ID_WIDTH.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 dispatch_valid / dispatch_ready  in / out  1 / 1  dispatch handshake; a transfer occurs when both are high.
REQ-007 dispatch_op / dispatch_dest_addr  in  8 / 5  opcode and destination GPR.
REQ-008 dispatch_a_valid, dispatch_a_value, dispatch_a_rs_id  in  1, 32, RS_ID_WIDTH  operand A as read from the GP register file; dispatch_b_* is identical for operand B.
REQ-009 dispatch_rs_id  out  RS_ID_WIDTH  ID of the entry that will take the current dispatch; drives the register-file update port.
REQ-010 cdb_valid, cdb_rs_id, cdb_value  in  1, RS_ID_WIDTH, 32  result broadcast snooped by all entries.
REQ-011 issue_valid / issue_ready  out / in  1 / 1  issue handshake to the execution unit.
REQ-012 issue_op, issue_a, issue_b, issue_dest_addr, issue_rs_id  out  8, 32, 32, 5, RS_ID_WIDTH  issued payload.

Function
REQ-013 Each entry SHALL hold: busy, op, dest_addr, and for each operand: valid, value, rs_id.
REQ-014 dispatch_ready SHALL be high iff at least one entry is not busy, computed from registered state only.
REQ-015 dispatch_rs_id SHALL be the ID of the lowest-index non-busy entry; it is 0 when the station is full.
REQ-016 On a dispatch transfer, the selected entry SHALL become busy the next cycle and latch the op, dest_addr and operands.
REQ-017 An operand dispatched with valid=0 whose rs_id equals cdb_rs_id while cdb_valid=1 in the same cycle SHALL be stored as valid with cdb_value.
REQ-018 Each busy entry SHALL compare every invalid operand's rs_id with cdb_rs_id each cycle; on a match while cdb_valid=1, it SHALL store cdb_value and set the operand valid. Valid operands SHALL ignore the CDB.
REQ-019 An entry SHALL be eligible for issue when it is busy and both operands are valid in registered state, i.e. no earlier than one cycle after the last capture.
REQ-020 The unit SHALL contain a two-state issue FSM:
  - IDLE: if any entry is eligible, latch the index of the lowest-index eligible entry and go to OFFER.
  - OFFER: issue_valid=1, with the payload taken from the latched entry. On issue_ready=1, clear that entry's busy bit and return to IDLE.
REQ-021 While in OFFER, the latched index and all issue_* outputs SHALL stay stable until the handshake, regardless of other entries becoming eligible.
REQ-022 An entry freed by issue SHALL NOT be reported free to dispatch in the same cycle; it becomes available the following cycle.
REQ-023 Dispatch, CDB capture and issue in the same cycle SHALL all take effect independently.
REQ-024 When the FSM is in IDLE, issue_valid=0 and issue_* SHALL be driven to 0.

Reset
REQ-025 While rst=1 at a clock edge:
  - all entries are cleared (busy=0, all fields 0);
  - the FSM goes to IDLE.
REQ-026 After reset: dispatch_ready=1, dispatch_rs_id=RS_BASE_ID, issue_valid=0, and all issue_* are 0. A reset during OFFER discards the offered instruction.

Configuration
REQ-027 Macro RS_FLUSH_EN:
  - Defined: adds input flush (1 bit). flush=1 at a clock edge clears all busy bits and returns the FSM to IDLE, with priority over dispatch, capture and issue.
  - Undefined: no flush port exists, and entries are freed only by issue or rst.

Verification
REQ-028 ENTRIES=4, RS_BASE_ID=8: dispatch four instructions with both operands valid and issue_ready=0. Required: dispatch_rs_id runs 8, 9, 10, 11, then dispatch_ready=0; issue_valid=1 with issue_rs_id=8.
REQ-029 Dispatch with A=0x00000005 valid and B invalid with rs_id 3. Then drive cdb_valid=1, cdb_rs_id=3, cdb_value=0x0000000A. Required: issue_valid rises one cycle later with issue_a=0x5, issue_b=0xA.
REQ-030 Dispatch with B invalid with rs_id 7 while cdb_valid=1, cdb_rs_id=7, cdb_value=0x12345678 in the same cycle. Required: the entry issues with issue_b=0x12345678 and no further CDB is needed.
REQ-031 Entry 1 is offered with issue_ready=0 for 5 cycles while entry 0 becomes eligible. Required: issue_rs_id stays at entry 1's ID until the handshake, then entry 0 is offered next.
REQ-032 Full station: issue handshake and dispatch_valid=1 in the same cycle. Required: dispatch_ready=0 in that cycle, then 1 the next cycle with dispatch_rs_id equal to the freed ID.
REQ-033 With RS_FLUSH_EN defined: three busy entries, one in OFFER, assert flush. Required: the next cycle has issue_valid=0, dispatch_ready=1, dispatch_rs_id=RS_BASE_ID.

Source files
------------

// File: rtl/gp_reservation_station.sv
// Reservation station for the general-purpose pipeline: holds dispatched ops until both operands
// are known (snooping the CDB), then offers them one at a time to the execution unit. Optional flush via RS_FLUSH_EN.
module gp_reservation_station #(
    parameter int ENTRIES     = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_BASE_ID  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef RS_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [7:0]             dispatch_op,
    input  logic [4:0]             dispatch_dest_addr,
    input  logic                   dispatch_a_valid,
    input  logic [31:0]            dispatch_a_value,
    input  logic [RS_ID_WIDTH-1:0] dispatch_a_rs_id,
    input  logic                   dispatch_b_valid,
    input  logic [31:0]            dispatch_b_value,
    input  logic [RS_ID_WIDTH-1:0] dispatch_b_rs_id,
    output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_value,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [7:0]             issue_op,
    output logic [31:0]            issue_a,
    output logic [31:0]            issue_b,
    output logic [4:0]             issue_dest_addr,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id
);

    localparam int IDX_W = $clog2(ENTRIES);

    typedef logic [IDX_W-1:0]       idx_t;
    typedef logic [RS_ID_WIDTH-1:0] id_t;
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OFFER = 1'b1} state_t;

    function automatic id_t entry_id(input idx_t idx);
        return id_t'(RS_BASE_ID + int'(idx));
    endfunction

    function automatic logic cdb_hit(input logic op_valid, input id_t op_id,
                                     input logic bus_valid, input id_t bus_id);
        return !op_valid && bus_valid && (op_id == bus_id);
    endfunction

    logic [ENTRIES-1:0] busy_r;
    logic [ENTRIES-1:0] a_valid_r;
    logic [ENTRIES-1:0] b_valid_r;
    logic [7:0]         op_r      [ENTRIES];
    logic [4:0]         dest_r    [ENTRIES];
    logic [31:0]        a_value_r [ENTRIES];
    logic [31:0]        b_value_r [ENTRIES];
    id_t                a_rs_id_r [ENTRIES];
    id_t                b_rs_id_r [ENTRIES];

    state_t             state_r;
    state_t             state_s;
    idx_t               sel_idx_r;
    logic [ENTRIES-1:0] elig_s;
    logic               elig_found_s;
    idx_t               elig_idx_s;
    logic               free_found_s;
    idx_t               free_idx_s;
    logic               dispatch_fire_s;
    logic               issue_fire_s;
    logic               load_s;
    logic               a_fwd_s;
    logic               b_fwd_s;

    logic [7:0]         issue_op_r;
    logic [31:0]        issue_a_r;
    logic [31:0]        issue_b_r;
    logic [4:0]         issue_dest_r;
    id_t                issue_rs_id_r;

    assign elig_s       = busy_r & a_valid_r & b_valid_r;
    assign elig_found_s = |elig_s;
    assign free_found_s = ~&busy_r;

    // Lowest-index free entry and lowest-index eligible entry
    always_comb begin
        free_idx_s = '0;
        elig_idx_s = '0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            free_idx_s = busy_r[k] ? free_idx_s : idx_t'(k);
            elig_idx_s = elig_s[k] ? idx_t'(k) : elig_idx_s;
        end
    end

    assign dispatch_ready  = free_found_s;
    assign dispatch_rs_id  = free_found_s ? entry_id(free_idx_s) : '0;
    assign dispatch_fire_s = dispatch_valid && free_found_s;
    assign a_fwd_s         = cdb_hit(dispatch_a_valid, dispatch_a_rs_id, cdb_valid, cdb_rs_id);
    assign b_fwd_s         = cdb_hit(dispatch_b_valid, dispatch_b_rs_id, cdb_valid, cdb_rs_id);

    // Entry storage: dispatch fill, CDB snooping, release on issue handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r    <= '0;
            a_valid_r <= '0;
            b_valid_r <= '0;
            for (int k = 0; k < ENTRIES; k++) begin
                op_r[k]      <= 8'h00;
                dest_r[k]    <= 5'd0;
                a_value_r[k] <= 32'h0000_0000;
                b_value_r[k] <= 32'h0000_0000;
                a_rs_id_r[k] <= '0;
                b_rs_id_r[k] <= '0;
            end
        end
`ifdef RS_FLUSH_EN
        else if (flush) begin
            busy_r <= '0;
        end
`endif
        else begin
            for (int k = 0; k < ENTRIES; k++) begin
                if (busy_r[k] && cdb_hit(a_valid_r[k], a_rs_id_r[k], cdb_valid, cdb_rs_id)) begin
                    a_valid_r[k] <= 1'b1;
                    a_value_r[k] <= cdb_value;
                end
                if (busy_r[k] && cdb_hit(b_valid_r[k], b_rs_id_r[k], cdb_valid, cdb_rs_id)) begin
                    b_valid_r[k] <= 1'b1;
                    b_value_r[k] <= cdb_value;
                end
            end
            // The free entry is never busy, so this cannot collide with snooping or release
            if (dispatch_fire_s) begin
                busy_r[free_idx_s]    <= 1'b1;
                op_r[free_idx_s]      <= dispatch_op;
                dest_r[free_idx_s]    <= dispatch_dest_addr;
                a_valid_r[free_idx_s] <= dispatch_a_valid | a_fwd_s;
                a_value_r[free_idx_s] <= a_fwd_s ? cdb_value : dispatch_a_value;
                a_rs_id_r[free_idx_s] <= dispatch_a_rs_id;
                b_valid_r[free_idx_s] <= dispatch_b_valid | b_fwd_s;
                b_value_r[free_idx_s] <= b_fwd_s ? cdb_value : dispatch_b_value;
                b_rs_id_r[free_idx_s] <= dispatch_b_rs_id;
            end
            if (issue_fire_s) begin
                busy_r[sel_idx_r] <= 1'b0;
            end
        end
    end

    // Issue FSM next-state and handshake decode
    always_comb begin
        state_s      = state_r;
        load_s       = 1'b0;
        issue_fire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s  = elig_found_s;
                state_s = elig_found_s ? ST_OFFER : ST_IDLE;
            end
            ST_OFFER: begin
                issue_fire_s = issue_ready;
                state_s      = issue_ready ? ST_IDLE : ST_OFFER;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Issue FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end
`ifdef RS_FLUSH_EN
        else if (flush) begin
            state_r <= ST_IDLE;
        end
`endif
        else begin
            state_r <= state_s;
        end
    end

    // Offered payload is frozen at selection time and zeroed whenever nothing is offered
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_idx_r     <= '0;
            issue_op_r    <= 8'h00;
            issue_a_r     <= 32'h0000_0000;
            issue_b_r     <= 32'h0000_0000;
            issue_dest_r  <= 5'd0;
            issue_rs_id_r <= '0;
        end
`ifdef RS_FLUSH_EN
        else if (flush) begin
            issue_op_r    <= 8'h00;
            issue_a_r     <= 32'h0000_0000;
            issue_b_r     <= 32'h0000_0000;
            issue_dest_r  <= 5'd0;
            issue_rs_id_r <= '0;
        end
`endif
        else if (load_s) begin
            sel_idx_r     <= elig_idx_s;
            issue_op_r    <= op_r[elig_idx_s];
            issue_a_r     <= a_value_r[elig_idx_s];
            issue_b_r     <= b_value_r[elig_idx_s];
            issue_dest_r  <= dest_r[elig_idx_s];
            issue_rs_id_r <= entry_id(elig_idx_s);
        end else if (issue_fire_s) begin
            issue_op_r    <= 8'h00;
            issue_a_r     <= 32'h0000_0000;
            issue_b_r     <= 32'h0000_0000;
            issue_dest_r  <= 5'd0;
            issue_rs_id_r <= '0;
        end
    end

    assign issue_valid     = (state_r == ST_OFFER);
    assign issue_op        = issue_op_r;
    assign issue_a         = issue_a_r;
    assign issue_b         = issue_b_r;
    assign issue_dest_addr = issue_dest_r;
    assign issue_rs_id     = issue_rs_id_r;

endmodule

// File: tb/tb_gp_reservation_station.sv
// Self-checking bench for gp_reservation_station (ENTRIES=4, RS_BASE_ID=8); flush scenario built when RS_FLUSH_EN is defined.
module tb_gp_reservation_station;

    localparam int ENTRIES = 4;
    localparam int IDW     = 5;
    localparam int BASE    = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
`ifdef RS_FLUSH_EN
    logic           flush = 1'b0;
`endif
    logic           dispatch_valid = 1'b0;
    logic           dispatch_ready;
    logic [7:0]     dispatch_op = 8'h00;
    logic [4:0]     dispatch_dest_addr = 5'd0;
    logic           dispatch_a_valid = 1'b0;
    logic [31:0]    dispatch_a_value = 32'h0;
    logic [IDW-1:0] dispatch_a_rs_id = '0;
    logic           dispatch_b_valid = 1'b0;
    logic [31:0]    dispatch_b_value = 32'h0;
    logic [IDW-1:0] dispatch_b_rs_id = '0;
    logic [IDW-1:0] dispatch_rs_id;
    logic           cdb_valid = 1'b0;
    logic [IDW-1:0] cdb_rs_id = '0;
    logic [31:0]    cdb_value = 32'h0;
    logic           issue_valid;
    logic           issue_ready = 1'b0;
    logic [7:0]     issue_op;
    logic [31:0]    issue_a;
    logic [31:0]    issue_b;
    logic [4:0]     issue_dest_addr;
    logic [IDW-1:0] issue_rs_id;

    int checks   = 0;
    int failures = 0;

    gp_reservation_station #(.ENTRIES(ENTRIES), .RS_ID_WIDTH(IDW), .RS_BASE_ID(BASE)) dut (
        .clk(clk), .rst(rst),
`ifdef RS_FLUSH_EN
        .flush(flush),
`endif
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op(dispatch_op), .dispatch_dest_addr(dispatch_dest_addr),
        .dispatch_a_valid(dispatch_a_valid), .dispatch_a_value(dispatch_a_value),
        .dispatch_a_rs_id(dispatch_a_rs_id),
        .dispatch_b_valid(dispatch_b_valid), .dispatch_b_value(dispatch_b_value),
        .dispatch_b_rs_id(dispatch_b_rs_id),
        .dispatch_rs_id(dispatch_rs_id),
        .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
        .issue_dest_addr(issue_dest_addr), .issue_rs_id(issue_rs_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] id_of(input int k);
        return 32'((BASE + k) % 32);
    endfunction

    // Reference model: a table of waiting instructions and whether one is being offered
    logic        m_busy [ENTRIES];
    logic [7:0]  m_op   [ENTRIES];
    logic [4:0]  m_dest [ENTRIES];
    logic        m_av   [ENTRIES];
    logic        m_bv   [ENTRIES];
    logic [31:0] m_aval [ENTRIES];
    logic [31:0] m_bval [ENTRIES];
    logic [4:0]  m_aid  [ENTRIES];
    logic [4:0]  m_bid  [ENTRIES];
    logic        m_offer = 1'b0;
    int          m_sel   = 0;
    logic        m_live  = 1'b0;

    // Compare outputs against the model mid-cycle, then advance the model over the coming edge
    always @(negedge clk) begin
        logic        exp_ready;
        logic [31:0] exp_id;
        int          fidx;
        int          eidx;
        logic        fire;
        logic        fwd;
        exp_ready = 1'b0;
        exp_id    = 32'h0;
        for (int k = ENTRIES - 1; k >= 0; k--) begin
            if (!m_busy[k]) begin
                exp_ready = 1'b1;
                exp_id    = id_of(k);
            end
        end
        if (m_live) begin
            check("dispatch_ready", 32'(dispatch_ready), 32'(exp_ready));
            check("dispatch_rs_id", 32'(dispatch_rs_id), exp_id);
            check("issue_valid", 32'(issue_valid), 32'(m_offer));
            check("issue_op", 32'(issue_op), m_offer ? 32'(m_op[m_sel]) : 32'h0);
            check("issue_a", issue_a, m_offer ? m_aval[m_sel] : 32'h0);
            check("issue_b", issue_b, m_offer ? m_bval[m_sel] : 32'h0);
            check("issue_dest", 32'(issue_dest_addr), m_offer ? 32'(m_dest[m_sel]) : 32'h0);
            check("issue_rs_id", 32'(issue_rs_id), m_offer ? id_of(m_sel) : 32'h0);
        end
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_busy[k] = 1'b0; m_op[k] = 8'h0; m_dest[k] = 5'd0;
                m_av[k] = 1'b0; m_bv[k] = 1'b0; m_aval[k] = 32'h0; m_bval[k] = 32'h0;
                m_aid[k] = 5'd0; m_bid[k] = 5'd0;
            end
            m_offer = 1'b0;
            m_sel   = 0;
            m_live  = 1'b1;
        end
`ifdef RS_FLUSH_EN
        else if (flush) begin
            for (int k = 0; k < ENTRIES; k++) m_busy[k] = 1'b0;
            m_offer = 1'b0;
        end
`endif
        else begin
            fidx = -1;
            eidx = -1;
            for (int k = 0; k < ENTRIES; k++) begin
                if (fidx < 0 && !m_busy[k]) fidx = k;
                if (eidx < 0 && m_busy[k] && m_av[k] && m_bv[k]) eidx = k;
            end
            fire = m_offer && issue_ready;
            for (int k = 0; k < ENTRIES; k++) begin
                if (m_busy[k] && cdb_valid && !m_av[k] && m_aid[k] == cdb_rs_id) begin
                    m_av[k] = 1'b1; m_aval[k] = cdb_value;
                end
                if (m_busy[k] && cdb_valid && !m_bv[k] && m_bid[k] == cdb_rs_id) begin
                    m_bv[k] = 1'b1; m_bval[k] = cdb_value;
                end
            end
            if (dispatch_valid && fidx >= 0) begin
                m_busy[fidx] = 1'b1;
                m_op[fidx]   = dispatch_op;
                m_dest[fidx] = dispatch_dest_addr;
                fwd = !dispatch_a_valid && cdb_valid && dispatch_a_rs_id == cdb_rs_id;
                m_av[fidx]   = dispatch_a_valid || fwd;
                m_aval[fidx] = fwd ? cdb_value : dispatch_a_value;
                m_aid[fidx]  = dispatch_a_rs_id;
                fwd = !dispatch_b_valid && cdb_valid && dispatch_b_rs_id == cdb_rs_id;
                m_bv[fidx]   = dispatch_b_valid || fwd;
                m_bval[fidx] = fwd ? cdb_value : dispatch_b_value;
                m_bid[fidx]  = dispatch_b_rs_id;
            end
            if (fire) begin
                m_busy[m_sel] = 1'b0;
                m_offer = 1'b0;
            end else if (!m_offer && eidx >= 0) begin
                m_offer = 1'b1;
                m_sel   = eidx;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [7:0] op, input logic [4:0] dest,
                        input logic av, input logic [31:0] aval, input logic [4:0] aid,
                        input logic bv, input logic [31:0] bval, input logic [4:0] bid);
        dispatch_valid = 1'b1; dispatch_op = op; dispatch_dest_addr = dest;
        dispatch_a_valid = av; dispatch_a_value = aval; dispatch_a_rs_id = aid;
        dispatch_b_valid = bv; dispatch_b_value = bval; dispatch_b_rs_id = bid;
    endtask

    task automatic drain();
        dispatch_valid = 1'b0;
        issue_ready = 1'b1;
        repeat (10) tick();
        issue_ready = 1'b0;
        check("drained_ready", 32'(dispatch_ready), 32'h1);
        check("drained_id", 32'(dispatch_rs_id), 32'd8);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", 32'(dispatch_ready), 32'h1);
        check("rst_id", 32'(dispatch_rs_id), 32'd8);
        check("rst_iv", 32'(issue_valid), 32'h0);
        check("rst_ia", issue_a, 32'h0);
        check("rst_irs", 32'(issue_rs_id), 32'h0);

        // Fill all four entries while the execution unit stalls
        for (int i = 0; i < 4; i++) begin
            check("fill_id", 32'(dispatch_rs_id), 32'(8 + i));
            disp(8'(i + 1), 5'(i + 1), 1'b1, 32'h100 + 32'(i), 5'd0, 1'b1, 32'h200 + 32'(i), 5'd0);
            tick();
        end
        dispatch_valid = 1'b0;
        check("fill_ready", 32'(dispatch_ready), 32'h0);
        check("fill_iv", 32'(issue_valid), 32'h1);
        check("fill_irs", 32'(issue_rs_id), 32'd8);
        check("fill_ia", issue_a, 32'h100);
        check("fill_ib", issue_b, 32'h200);
        drain();

        // Operand B waits for the CDB
        disp(8'h21, 5'd3, 1'b1, 32'h5, 5'd0, 1'b0, 32'h0, 5'd3);
        tick();
        dispatch_valid = 1'b0;
        tick();
        tick();
        check("wait_iv", 32'(issue_valid), 32'h0);
        cdb_valid = 1'b1; cdb_rs_id = 5'd3; cdb_value = 32'hA;
        tick();
        cdb_valid = 1'b0;
        check("cap_iv_early", 32'(issue_valid), 32'h0);
        tick();
        check("cap_iv", 32'(issue_valid), 32'h1);
        check("cap_ia", issue_a, 32'h5);
        check("cap_ib", issue_b, 32'hA);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        tick();

        // Operand B forwarded from the CDB in the dispatch cycle
        disp(8'h31, 5'd7, 1'b1, 32'h11, 5'd0, 1'b0, 32'hDEAD, 5'd7);
        cdb_valid = 1'b1; cdb_rs_id = 5'd7; cdb_value = 32'h12345678;
        tick();
        dispatch_valid = 1'b0;
        cdb_valid = 1'b0;
        tick();
        check("fwd_iv", 32'(issue_valid), 32'h1);
        check("fwd_ia", issue_a, 32'h11);
        check("fwd_ib", issue_b, 32'h12345678);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        tick();

        // Entry 1 is offered first and must hold while entry 0 becomes eligible
        disp(8'h40, 5'd1, 1'b0, 32'h0, 5'd20, 1'b1, 32'h66, 5'd0);
        tick();
        disp(8'h41, 5'd2, 1'b0, 32'h0, 5'd21, 1'b1, 32'h88, 5'd0);
        cdb_valid = 1'b1; cdb_rs_id = 5'd21; cdb_value = 32'h77;
        tick();
        dispatch_valid = 1'b0;
        cdb_valid = 1'b0;
        tick();
        check("hold_irs0", 32'(issue_rs_id), 32'd9);
        check("hold_ia0", issue_a, 32'h77);
        cdb_valid = 1'b1; cdb_rs_id = 5'd20; cdb_value = 32'h55;
        tick();
        cdb_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_irs", 32'(issue_rs_id), 32'd9);
            tick();
        end
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        check("hold_gap_iv", 32'(issue_valid), 32'h0);
        tick();
        check("next_irs", 32'(issue_rs_id), 32'd8);
        check("next_ia", issue_a, 32'h55);
        check("next_ib", issue_b, 32'h66);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        tick();

        // Full station: a freed entry is not offered to dispatch in the freeing cycle
        for (int i = 0; i < 4; i++) begin
            disp(8'h50 + 8'(i), 5'(i), 1'b1, 32'h300 + 32'(i), 5'd0, 1'b1, 32'h400 + 32'(i), 5'd0);
            tick();
        end
        disp(8'h60, 5'd9, 1'b1, 32'h500, 5'd0, 1'b1, 32'h600, 5'd0);
        issue_ready = 1'b1;
        check("full_ready", 32'(dispatch_ready), 32'h0);
        tick();
        issue_ready = 1'b0;
        check("freed_ready", 32'(dispatch_ready), 32'h1);
        check("freed_id", 32'(dispatch_rs_id), 32'd8);
        tick();
        dispatch_valid = 1'b0;
        check("refull_ready", 32'(dispatch_ready), 32'h0);
        drain();

`ifdef RS_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            disp(8'h70 + 8'(i), 5'(i), 1'b1, 32'h700 + 32'(i), 5'd0, 1'b1, 32'h800, 5'd0);
            tick();
        end
        dispatch_valid = 1'b0;
        check("pre_flush_iv", 32'(issue_valid), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_iv", 32'(issue_valid), 32'h0);
        check("flush_ready", 32'(dispatch_ready), 32'h1);
        check("flush_id", 32'(dispatch_rs_id), 32'd8);
        tick();
`endif

        // Reset while an instruction is on offer
        disp(8'h90, 5'd4, 1'b1, 32'h900, 5'd0, 1'b1, 32'hA00, 5'd0);
        tick();
        dispatch_valid = 1'b0;
        tick();
        check("pre_rst_iv", 32'(issue_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_iv", 32'(issue_valid), 32'h0);
        check("post_rst_ready", 32'(dispatch_ready), 32'h1);
        check("post_rst_id", 32'(dispatch_rs_id), 32'd8);
        tick();
        tick();
        check("post_rst_quiet", 32'(issue_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
